// File: rtl/npu_pkg.sv
// Shared NPU definitions: datapath widths, pool FSM state and the unsigned
// saturation helper used by the requantizer.
package npu_pkg;

  localparam int DATA_WIDTH = 24;
  localparam int OUT_WIDTH  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POOL = 2'd1,
    DONE = 2'd2
  } pool_state_t;

  // Clamp a signed value into the unsigned range [0, 2^w-1]; result is
  // returned in the low bits of an OUT_WIDTH word.
  function automatic logic [OUT_WIDTH-1:0] sat_u(input logic signed [DATA_WIDTH:0] val,
                                                 input int w);
    logic [DATA_WIDTH:0] lim;
    lim = ~({(DATA_WIDTH+1){1'b1}} << w);
    if (val < 0)
      sat_u = '0;
    else if ($unsigned(val) > lim)
      sat_u = lim[OUT_WIDTH-1:0];
    else
      sat_u = val[OUT_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/requant_sat.sv
// requant_sat: combinational 2x2 max, arithmetic right shift, optional
// round-half-up, then unsigned saturation to OUT_WIDTH.
// Optional feature macro: POOL_ROUND_EN (adds 2^(shift-1) before shifting).
module requant_sat
  import npu_pkg::*;
#(
  parameter int DATA_WIDTH = npu_pkg::DATA_WIDTH,
  parameter int OUT_WIDTH  = npu_pkg::OUT_WIDTH,
  parameter int SHIFT_W    = 5
) (
  input  logic signed [DATA_WIDTH-1:0] i_a,
  input  logic signed [DATA_WIDTH-1:0] i_b,
  input  logic signed [DATA_WIDTH-1:0] i_c,
  input  logic signed [DATA_WIDTH-1:0] i_d,
  input  logic        [SHIFT_W-1:0]    i_shift,
  output logic        [OUT_WIDTH-1:0]  o_data
);

  logic signed [DATA_WIDTH-1:0] w_max_ab;
  logic signed [DATA_WIDTH-1:0] w_max_cd;
  logic signed [DATA_WIDTH-1:0] w_max;
  logic signed [DATA_WIDTH:0]   w_ext;
  logic signed [DATA_WIDTH:0]   w_shr;
  logic signed [DATA_WIDTH:0]   w_val;

  assign w_max_ab = (i_a > i_b) ? i_a : i_b;
  assign w_max_cd = (i_c > i_d) ? i_c : i_d;
  assign w_max    = (w_max_ab > w_max_cd) ? w_max_ab : w_max_cd;

  // One guard bit keeps any rounding increment from wrapping.
  assign w_ext = {w_max[DATA_WIDTH-1], w_max};
  assign w_shr = w_ext >>> i_shift;

`ifdef POOL_ROUND_EN
  // floor((x + 2^(s-1)) / 2^s) == floor(x / 2^s) + bit (s-1) of x, which stays
  // exact for every shift amount, including shifts wider than the data.
  logic w_rnd;
  assign w_rnd = (i_shift != '0) &&
                 (((w_ext >>> (i_shift - SHIFT_W'(1))) & (DATA_WIDTH+1)'(1)) != '0);
  assign w_val = w_shr + (DATA_WIDTH+1)'(w_rnd);
`else
  assign w_val = w_shr;
`endif

  assign o_data = sat_u(w_val, OUT_WIDTH);

endmodule

// File: rtl/pool_requant.sv
// pool_requant: captures an H x W map of signed accumulator sums, performs
// 2x2/stride-2 max pooling with requantization to unsigned OUT_WIDTH, and
// streams the PH x PW results row-major over a valid/ready interface.
// Optional feature macro: POOL_ROUND_EN (round-half-up before the shift,
// implemented inside requant_sat).
module pool_requant
  import npu_pkg::*;
#(
  parameter int DATA_WIDTH = npu_pkg::DATA_WIDTH,
  parameter int H          = 12,
  parameter int W          = 11,
  parameter int OUT_WIDTH  = npu_pkg::OUT_WIDTH,
  parameter int SHIFT_W    = 5,
  localparam int PH        = H / 2,
  localparam int PW        = W / 2,
  localparam int RW        = (PH > 1) ? $clog2(PH) : 1,
  localparam int CW        = (PW > 1) ? $clog2(PW) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] in_data [H][W],
  input  logic        [SHIFT_W-1:0]    cfg_shift,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic        [OUT_WIDTH-1:0]  out_data,
  output logic        [RW-1:0]         out_row,
  output logic        [CW-1:0]         out_col,
  output logic                         frame_done
);

  localparam int IW = (H > 1) ? $clog2(H) : 1;
  localparam int JW = (W > 1) ? $clog2(W) : 1;

  pool_state_t r_state;
  pool_state_t w_state_nxt;

  logic signed [DATA_WIDTH-1:0] r_buf [H][W];
  logic        [SHIFT_W-1:0]    r_shift;

  logic [RW-1:0] r_wr;
  logic [CW-1:0] r_wc;
  logic          r_all_issued;

  logic                 r_out_valid;
  logic [OUT_WIDTH-1:0] r_out_data;
  logic [RW-1:0]        r_out_row;
  logic [CW-1:0]        r_out_col;
  logic                 r_frame_done;

  logic w_cap;
  logic w_accept;
  logic w_accept_last;
  logic w_load;
  logic w_win_last;

  logic [IW-1:0] w_ri0;
  logic [IW-1:0] w_ri1;
  logic [JW-1:0] w_cj0;
  logic [JW-1:0] w_cj1;
  logic signed [DATA_WIDTH-1:0] w_win_a;
  logic signed [DATA_WIDTH-1:0] w_win_b;
  logic signed [DATA_WIDTH-1:0] w_win_c;
  logic signed [DATA_WIDTH-1:0] w_win_d;
  logic [OUT_WIDTH-1:0]         w_q;
  logic                         w_unused_tail;

  assign w_cap         = in_valid && in_ready;
  assign w_accept      = r_out_valid && out_ready;
  assign w_accept_last = w_accept && (r_out_row == RW'(PH - 1)) && (r_out_col == CW'(PW - 1));
  assign w_win_last    = (r_wr == RW'(PH - 1)) && (r_wc == CW'(PW - 1));
  // The output register refills whenever it is empty or draining this cycle.
  assign w_load        = (r_state == POOL) && !r_all_issued && (!r_out_valid || out_ready);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic: IDLE -> POOL on capture, POOL -> DONE on last beat, DONE -> IDLE
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_cap)         w_state_nxt = POOL;
      POOL:    if (w_accept_last) w_state_nxt = DONE;
      DONE:                       w_state_nxt = IDLE;
      default:                    w_state_nxt = IDLE;
    endcase
  end

  // FSM outputs: a new map is accepted only while idle
  always_comb begin
    in_ready = (r_state == IDLE);
  end

  // Capture the whole map and the shift amount on the input handshake
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < H; i++)
        for (int j = 0; j < W; j++)
          r_buf[i][j] <= '0;
      r_shift <= '0;
    end else if (w_cap) begin
      for (int i = 0; i < H; i++)
        for (int j = 0; j < W; j++)
          r_buf[i][j] <= in_data[i][j];
      r_shift <= cfg_shift;
    end
  end

  // Window counters: restart at (0,0) on capture, advance row-major on each load
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr         <= '0;
      r_wc         <= '0;
      r_all_issued <= 1'b0;
    end else if (w_cap) begin
      r_wr         <= '0;
      r_wc         <= '0;
      r_all_issued <= 1'b0;
    end else if (w_load) begin
      if (w_win_last) begin
        r_all_issued <= 1'b1;
      end else if (r_wc == CW'(PW - 1)) begin
        r_wc <= '0;
        r_wr <= r_wr + RW'(1);
      end else begin
        r_wc <= r_wc + CW'(1);
      end
    end
  end

  // Select the four cells of the current window from the capture buffer
  always_comb begin
    w_ri0   = IW'({r_wr, 1'b0});
    w_ri1   = IW'({r_wr, 1'b1});
    w_cj0   = JW'({r_wc, 1'b0});
    w_cj1   = JW'({r_wc, 1'b1});
    w_win_a = r_buf[w_ri0][w_cj0];
    w_win_b = r_buf[w_ri0][w_cj1];
    w_win_c = r_buf[w_ri1][w_cj0];
    w_win_d = r_buf[w_ri1][w_cj1];
  end

  // Fold the odd trailing row/column into a dummy so they read as used
  always_comb begin
    w_unused_tail = 1'b0;
    for (int i = 0; i < H; i++)
      for (int j = 0; j < W; j++)
        if (i >= 2 * PH || j >= 2 * PW)
          w_unused_tail = w_unused_tail ^ (^r_buf[i][j]);
  end

  requant_sat #(
    .DATA_WIDTH (DATA_WIDTH),
    .OUT_WIDTH  (OUT_WIDTH),
    .SHIFT_W    (SHIFT_W)
  ) u_requant (
    .i_a     (w_win_a),
    .i_b     (w_win_b),
    .i_c     (w_win_c),
    .i_d     (w_win_d),
    .i_shift (r_shift),
    .o_data  (w_q)
  );

  // Output register: load the next window, or drop valid once the last beat drains
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_row   <= '0;
      r_out_col   <= '0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_q;
      r_out_row   <= r_wr;
      r_out_col   <= r_wc;
    end else if (w_accept) begin
      r_out_valid <= 1'b0;
    end
  end

  // One-cycle completion pulse after the final beat is taken
  always_ff @(posedge clk) begin
    if (!rst_n) r_frame_done <= 1'b0;
    else        r_frame_done <= w_accept_last;
  end

  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign out_row    = r_out_row;
  assign out_col    = r_out_col;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_pool_requant.sv
// Directed testbench for pool_requant (12x11 map -> 6x5 pooled stream).
// Expected rounding result follows POOL_ROUND_EN when the macro is defined.
module tb_pool_requant;

  localparam int NB = 30;

  logic                clk;
  logic                rst_n;
  logic                in_valid;
  logic                in_ready;
  logic signed [23:0]  din [12][11];
  logic        [4:0]   cfg_shift;
  logic                out_valid;
  logic                out_ready;
  logic        [7:0]   out_data;
  logic        [2:0]   out_row;
  logic        [2:0]   out_col;
  logic                frame_done;

  int n_vec;
  int n_err;
  int exp_q [NB];
  bit ab;

  pool_requant dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (din),
    .cfg_shift  (cfg_shift),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_row    (out_row),
    .out_col    (out_col),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_all(input int v);
    for (int i = 0; i < 12; i++)
      for (int j = 0; j < 11; j++)
        din[i][j] = 24'(v);
  endtask

  // in_data[i][j] = i*11 + j; window (r,c) max is (2r+1)*11 + (2c+1)
  task automatic fill_ramp();
    for (int i = 0; i < 12; i++)
      for (int j = 0; j < 11; j++)
        din[i][j] = 24'(i * 11 + j);
    for (int k = 0; k < NB; k++)
      exp_q[k] = (2 * (k / 5) + 1) * 11 + 2 * (k % 5) + 1;
  endtask

  task automatic send_frame(input logic [4:0] sh);
    int waitc;
    waitc = 0;
    while (!in_ready && waitc < 50) begin
      step();
      waitc++;
    end
    chk("pre_in_ready", in_ready, 1);
    cfg_shift = sh;
    in_valid  = 1'b1;
    step();
    in_valid = 1'b0;
    chk("lat_c1_valid", out_valid, 0);
    chk("lat_c1_in_ready", in_ready, 0);
    step();
    chk("lat_c2_valid", out_valid, 1);
  endtask

  task automatic collect(input int stall_at, input int stall_len, input bit poke,
                         input int abort_at, output bit aborted);
    int beat, cyc, stall_cnt, fd_cnt;
    logic [31:0] h_data, h_row, h_col;
    beat = 0; cyc = 0; stall_cnt = 0; fd_cnt = 0; aborted = 1'b0;
    h_data = '0; h_row = '0; h_col = '0;
    while (beat < NB && cyc < 400) begin
      if (frame_done) fd_cnt++;
      if (out_valid) begin
        if (beat == abort_at) begin
          rst_n     = 1'b0;
          out_ready = 1'b1;
          aborted   = 1'b1;
          break;
        end
        if (beat == stall_at && stall_cnt < stall_len) begin
          if (stall_cnt == 0) begin
            h_data = 32'(out_data); h_row = 32'(out_row); h_col = 32'(out_col);
          end else begin
            chk("hold_data", out_data, h_data);
            chk("hold_row", out_row, h_row);
            chk("hold_col", out_col, h_col);
          end
          chk("stall_in_ready", in_ready, 0);
          out_ready = 1'b0;
          in_valid  = poke;
          stall_cnt++;
        end else begin
          if (beat == stall_at && stall_len > 0) begin
            chk("hold_data", out_data, h_data);
            chk("hold_row", out_row, h_row);
            chk("hold_col", out_col, h_col);
          end
          in_valid  = 1'b0;
          out_ready = 1'b1;
          chk("beat_row", out_row, beat / 5);
          chk("beat_col", out_col, beat % 5);
          chk("beat_data", out_data, exp_q[beat]);
          beat++;
        end
      end else begin
        out_ready = 1'b1;
        in_valid  = 1'b0;
      end
      step();
      cyc++;
    end
    if (!aborted) begin
      chk("beat_count", beat, NB);
      chk("fd_early", fd_cnt, 0);
      chk("fd_pulse", frame_done, 1);
      chk("done_out_valid", out_valid, 0);
      chk("done_in_ready", in_ready, 0);
      step();
      chk("fd_clear", frame_done, 0);
      chk("idle_in_ready", in_ready, 1);
    end
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; cfg_shift = '0;
    fill_all(0);
    repeat (3) step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_row", out_row, 0);
    chk("rst_out_col", out_col, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;
    step();

    // Ramp, shift 0: 12, 14, ..., 130; column 10 never contributes
    fill_ramp();
    send_frame(5'd0);
    collect(-1, 0, 1'b0, -1, ab);

    // Same ramp, backpressure at beat (2,3), in_valid poked and shift changed mid-frame
    send_frame(5'd0);
    cfg_shift = 5'd5;
    collect(13, 3, 1'b1, -1, ab);

    // Constant 1000: >>2 gives 250, >>1 gives 500 which saturates to 255
    fill_all(1000);
    for (int k = 0; k < NB; k++) exp_q[k] = 250;
    send_frame(5'd2);
    collect(-1, 0, 1'b0, -1, ab);
    for (int k = 0; k < NB; k++) exp_q[k] = 255;
    send_frame(5'd1);
    collect(-1, 0, 1'b0, -1, ab);

    // Signed windows: all-negative -> 0, mixed -> 3, 300 -> 255, 200 beats 199
    fill_all(-1000);
    din[0][0] = -24'sd5;  din[0][1] = -24'sd7;  din[1][0] = -24'sd1; din[1][1] = -24'sd9;
    din[0][2] = -24'sd5;  din[0][3] = 24'sd3;   din[1][2] = -24'sd1; din[1][3] = 24'sd2;
    din[0][4] = 24'sd300; din[0][5] = -24'sd2;  din[1][4] = 24'sd5;  din[1][5] = 24'sd1;
    din[0][6] = -24'sd1000000; din[0][7] = 24'sd200; din[1][6] = -24'sd3; din[1][7] = 24'sd199;
    din[0][10] = 24'sd5000; din[11][10] = 24'sd5000;
    for (int k = 0; k < NB; k++) exp_q[k] = 0;
    exp_q[1] = 3; exp_q[2] = 255; exp_q[3] = 200;
    send_frame(5'd0);
    collect(-1, 0, 1'b0, -1, ab);

    // 7 >> 1: truncation gives 3, round-half-up gives 4
    fill_all(7);
`ifdef POOL_ROUND_EN
    for (int k = 0; k < NB; k++) exp_q[k] = 4;
`else
    for (int k = 0; k < NB; k++) exp_q[k] = 3;
`endif
    send_frame(5'd1);
    collect(-1, 0, 1'b0, -1, ab);

    // Reset asserted while beat (3,1) is presented
    fill_ramp();
    send_frame(5'd0);
    collect(-1, 0, 1'b0, 16, ab);
    chk("abort_reached", ab, 1);
    step();
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_out_row", out_row, 0);
    chk("mid_rst_out_col", out_col, 0);
    chk("mid_rst_out_data", out_data, 0);
    chk("mid_rst_frame_done", frame_done, 0);
    rst_n = 1'b1;
    step();

    // Fresh frame after the reset starts again at (0,0)
    send_frame(5'd0);
    collect(-1, 0, 1'b0, -1, ab);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
